// File: rtl/uart_fifo_link.sv
// UART endpoint: tick generator, glitch-rejecting RX with framing check, FWFT RX FIFO, TX serialiser.
// Optional build macro UART_ASCII_FILTER_EN keeps only printable ASCII and CR in the RX FIFO.
module uart_fifo_link #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned RX_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 frame_err,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready
);

  localparam int unsigned DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = $clog2(DIV + 1);
  localparam int unsigned CW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);
  localparam int unsigned AW  = $clog2(RX_DEPTH);

`ifdef UART_ASCII_FILTER_EN
  if (DATA_BITS != 8) begin : g_bad_width
    $error("UART_ASCII_FILTER_EN requires DATA_BITS == 8");
  end
`endif

  // Oversample tick
  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DW'(1);
  end

  // RX synchroniser
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX deserialiser
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 push_q, push_d;
  logic                 fe_q, fe_d;
  logic                 byte_ok;

`ifdef UART_ASCII_FILTER_EN
  assign byte_ok = ((rx_sh_q >= DATA_BITS'(8'h20)) && (rx_sh_q <= DATA_BITS'(8'h7E))) ||
                   (rx_sh_q == DATA_BITS'(8'h0D));
`else
  assign byte_ok = 1'b1;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    push_d     = 1'b0;
    fe_d       = 1'b0;
    if (tick) begin
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            rx_state_d = RxStart;
            rx_cnt_d   = '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        RxData: begin
          if (rx_cnt_q == CW'(OVERSAMPLE - 1)) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = RxStop;
            else                                rx_bit_d   = rx_bit_q + BW'(1);
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        RxStop: begin
          if (rx_cnt_q == CW'(OVERSAMPLE - 1)) begin
            rx_cnt_d   = '0;
            rx_state_d = RxIdle;
            if (rx_sync_q) push_d = byte_ok;
            else           fe_d   = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      push_q     <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      push_q     <= push_d;
      fe_q       <= fe_d;
    end
  end

  assign frame_err = fe_q;

  // RX FIFO; rx_sh_q stays stable through the push cycle
  logic [DATA_BITS-1:0] mem [RX_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic                 full, pop, wr_en;

  assign rx_valid   = (wr_q != rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = rx_valid & rx_ready;
  assign wr_en      = push_q & (~full | pop);
  assign rx_overrun = push_q & full & ~pop;
  assign rx_data    = rx_valid ? mem[rd_q[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (pop)   rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= rx_sh_q;
  end

  // TX serialiser; TxAlign holds the line idle until the next tick after acceptance
  typedef enum logic [2:0] {TxIdle, TxAlign, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_valid) begin
          tx_sh_d    = tx_data;
          tx_state_d = TxAlign;
        end
      end
      TxAlign: begin
        if (tick) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TxStart: begin
        if (tick) begin
          if (tx_cnt_q == CW'(OVERSAMPLE - 1)) begin
            tx_state_d = TxData;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_d       = tx_sh_q[0];
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      TxData: begin
        if (tick) begin
          if (tx_cnt_q == CW'(OVERSAMPLE - 1)) begin
            tx_cnt_d = '0;
            if (tx_bit_q == BW'(DATA_BITS - 1)) begin
              tx_state_d = TxStop;
              tx_d       = 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + BW'(1);
              tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
              tx_d     = tx_sh_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      TxStop: begin
        if (tick) begin
          if (tx_cnt_q == CW'(OVERSAMPLE - 1)) tx_state_d = TxIdle;
          else                                 tx_cnt_d   = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == TxIdle);

endmodule
